// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle control unit:
// ALU mnemonics, opcodes, operand-B select, error codes, FSM states.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        SLL = 3'd2,
        SRL = 3'd3,
        SLT = 3'd4
    } op_mne;

    localparam int OP_LOAD  = 0;
    localparam int OP_SUBI  = 1;
    localparam int OP_STORE = 2;
    localparam int OP_BEQZ  = 3;
    localparam int OP_BLTZ  = 4;
    localparam int OP_HALT  = 15;

    localparam logic [1:0] SRC_REG  = 2'd0;
    localparam logic [1:0] SRC_IMM  = 2'd1;
    localparam logic [1:0] SRC_ZERO = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED
    } ctl_state_t;

    typedef struct packed {
        op_mne      alu_op;
        logic [1:0] alu_src_b;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       branch;
        logic       br_neg;
        logic       mem_rd;
        logic       mem_wr;
        logic       legal;
        logic       halt;
    } exec_ctl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational map from the latched opcode to EXEC-phase controls.
// Purely a lookup; sequencing lives in multicycle_control.
module mc_decode
    import multicycle_control_pkg::*;
#(
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0] opcode,
    output exec_ctl_t       ctl
);

    always_comb begin
        ctl           = '0;
        ctl.alu_op    = ADD;
        ctl.alu_src_b = SRC_REG;
        unique case (1'b1)
            opcode == OP_W'(OP_LOAD): begin
                ctl.alu_op    = ADD;
                ctl.alu_src_b = SRC_ZERO;
                ctl.reg_dst   = 1'b1;
                ctl.mem_rd    = 1'b1;
                ctl.legal     = 1'b1;
            end
            opcode == OP_W'(OP_SUBI): begin
                ctl.alu_op     = SUB;
                ctl.alu_src_b  = SRC_IMM;
                ctl.mem_to_reg = 1'b1;
                ctl.legal      = 1'b1;
            end
            opcode == OP_W'(OP_STORE): begin
                ctl.alu_op    = SLL;
                ctl.alu_src_b = SRC_ZERO;
                ctl.mem_wr    = 1'b1;
                ctl.legal     = 1'b1;
            end
            opcode == OP_W'(OP_BEQZ): begin
                ctl.alu_op    = SRL;
                ctl.alu_src_b = SRC_ZERO;
                ctl.branch    = 1'b1;
                ctl.legal     = 1'b1;
            end
            opcode == OP_W'(OP_BLTZ): begin
                ctl.alu_op    = SLT;
                ctl.alu_src_b = SRC_ZERO;
                ctl.branch    = 1'b1;
                ctl.br_neg    = 1'b1;
                ctl.legal     = 1'b1;
            end
            opcode == OP_W'(OP_HALT): begin
                ctl.halt = 1'b1;
            end
            default: begin
                ctl.legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer with memory wait/timeout handling,
// illegal-opcode trap and a saturating retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [OP_W-1:0]  OPCODE,
    input  logic             ZERO,
    input  logic             NEG,
    output logic             IMEM_REQ,
    input  logic             IMEM_ACK,
    output logic             DMEM_REQ,
    input  logic             DMEM_ACK,
    output op_mne            ALU_OP,
    output logic [1:0]       ALU_SRC_B,
    output logic             REG_WRITE,
    output logic             MEM_WRITE,
    output logic             MEM_READ,
    output logic             REG_DST,
    output logic             MEM_TO_REG,
    output logic             BRANCH,
    output logic             PC_WRITE,
    output logic             PC_SRC,
    output logic             IR_WRITE,
    output logic             HALT,
    output logic [1:0]       ERR,
    output logic [CNT_W-1:0] INSN_COUNT
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    ctl_state_t        state;
    logic [OP_W-1:0]   opcode_q;
    logic [WAIT_W-1:0] wait_cnt;
    exec_ctl_t         dec;
    logic              br_taken;
    logic              wait_done;
    logic [CNT_W-1:0]  cnt_inc;

    mc_decode #(
        .OP_W (OP_W)
    ) u_dec (
        .opcode (opcode_q),
        .ctl    (dec)
    );

    assign br_taken  = dec.br_neg ? NEG : ZERO;
    assign wait_done = (wait_cnt == WAIT_LAST);
    assign cnt_inc   = (INSN_COUNT == CNT_MAX) ? INSN_COUNT
                                               : INSN_COUNT + 1'b1;

    // Outputs are registered toward the state being entered, so each
    // one is valid for exactly the cycles spent in that state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            opcode_q   <= '0;
            wait_cnt   <= '0;
            ERR        <= ERR_NONE;
            INSN_COUNT <= '0;
            IMEM_REQ   <= 1'b0;
            DMEM_REQ   <= 1'b0;
            ALU_OP     <= ADD;
            ALU_SRC_B  <= SRC_REG;
            REG_WRITE  <= 1'b0;
            MEM_WRITE  <= 1'b0;
            MEM_READ   <= 1'b0;
            REG_DST    <= 1'b0;
            MEM_TO_REG <= 1'b0;
            BRANCH     <= 1'b0;
            PC_WRITE   <= 1'b0;
            PC_SRC     <= 1'b0;
            IR_WRITE   <= 1'b0;
            HALT       <= 1'b0;
        end else begin
            IR_WRITE  <= 1'b0;
            PC_WRITE  <= 1'b0;
            PC_SRC    <= 1'b0;
            BRANCH    <= 1'b0;
            REG_WRITE <= 1'b0;
            unique case (state)
                S_IDLE, S_HALTED: begin
                    if (START) begin
                        state    <= S_FETCH;
                        ERR      <= ERR_NONE;
                        wait_cnt <= '0;
                        IMEM_REQ <= 1'b1;
                        HALT     <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (IMEM_ACK) begin
                        state    <= S_DECODE;
                        opcode_q <= OPCODE;
                        IMEM_REQ <= 1'b0;
                        IR_WRITE <= 1'b1;
                        PC_WRITE <= 1'b1;
                    end else if (wait_done) begin
                        state    <= S_HALTED;
                        IMEM_REQ <= 1'b0;
                        HALT     <= 1'b1;
                        ERR      <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec.legal) begin
                        state      <= S_EXEC;
                        ALU_OP     <= dec.alu_op;
                        ALU_SRC_B  <= dec.alu_src_b;
                        REG_DST    <= dec.reg_dst;
                        MEM_TO_REG <= dec.mem_to_reg;
                        BRANCH     <= dec.branch;
                    end else begin
                        state <= S_HALTED;
                        HALT  <= 1'b1;
                        if (dec.halt) begin
                            INSN_COUNT <= cnt_inc;
                        end else begin
                            ERR <= ERR_ILLEGAL;
                        end
                    end
                end
                S_EXEC: begin
                    if (dec.branch) begin
                        state      <= S_FETCH;
                        wait_cnt   <= '0;
                        IMEM_REQ   <= 1'b1;
                        PC_WRITE   <= br_taken;
                        PC_SRC     <= br_taken;
                        INSN_COUNT <= cnt_inc;
                    end else if (dec.mem_rd || dec.mem_wr) begin
                        state     <= S_MEM;
                        wait_cnt  <= '0;
                        DMEM_REQ  <= 1'b1;
                        MEM_READ  <= dec.mem_rd;
                        MEM_WRITE <= dec.mem_wr;
                    end else begin
                        state     <= S_WB;
                        REG_WRITE <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (DMEM_ACK) begin
                        DMEM_REQ  <= 1'b0;
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        if (dec.mem_rd) begin
                            state     <= S_WB;
                            REG_WRITE <= 1'b1;
                        end else begin
                            state      <= S_FETCH;
                            wait_cnt   <= '0;
                            IMEM_REQ   <= 1'b1;
                            INSN_COUNT <= cnt_inc;
                        end
                    end else if (wait_done) begin
                        state     <= S_HALTED;
                        DMEM_REQ  <= 1'b0;
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        HALT      <= 1'b1;
                        ERR       <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    state      <= S_FETCH;
                    wait_cnt   <= '0;
                    IMEM_REQ   <= 1'b1;
                    INSN_COUNT <= cnt_inc;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed corner cases plus random
// instruction streams checked against a latency/table reference model.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int OP_W = 5;
    localparam int TMO  = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            START = 1'b0;
    logic [OP_W-1:0] OPCODE = '0;
    logic            ZERO = 1'b0;
    logic            NEG = 1'b0;
    logic            IMEM_ACK = 1'b0;
    logic            DMEM_ACK = 1'b0;
    logic            IMEM_REQ, DMEM_REQ;
    op_mne           ALU_OP;
    logic [1:0]      ALU_SRC_B, ERR;
    logic            REG_WRITE, MEM_WRITE, MEM_READ, REG_DST;
    logic            MEM_TO_REG, BRANCH, PC_WRITE, PC_SRC;
    logic            IR_WRITE, HALT;
    logic [CW-1:0]   INSN_COUNT;

    int checks = 0;
    int failures = 0;
    int model_cnt = 0;

    multicycle_control #(
        .OP_W    (OP_W),
        .TIMEOUT (TMO),
        .CNT_W   (CW)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .OPCODE     (OPCODE),
        .ZERO       (ZERO),
        .NEG        (NEG),
        .IMEM_REQ   (IMEM_REQ),
        .IMEM_ACK   (IMEM_ACK),
        .DMEM_REQ   (DMEM_REQ),
        .DMEM_ACK   (DMEM_ACK),
        .ALU_OP     (ALU_OP),
        .ALU_SRC_B  (ALU_SRC_B),
        .REG_WRITE  (REG_WRITE),
        .MEM_WRITE  (MEM_WRITE),
        .MEM_READ   (MEM_READ),
        .REG_DST    (REG_DST),
        .MEM_TO_REG (MEM_TO_REG),
        .BRANCH     (BRANCH),
        .PC_WRITE   (PC_WRITE),
        .PC_SRC     (PC_SRC),
        .IR_WRITE   (IR_WRITE),
        .HALT       (HALT),
        .ERR        (ERR),
        .INSN_COUNT (INSN_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic int base_lat(input int op);
        case (op)
            0:       return 5;
            1, 2:    return 4;
            3, 4:    return 3;
            default: return 2;
        endcase
    endfunction

    function automatic op_mne exp_alu(input int op);
        case (op)
            0:       return ADD;
            1:       return SUB;
            2:       return SLL;
            3:       return SRL;
            default: return SLT;
        endcase
    endfunction

    task automatic run_insn(input int op, input int iw, input int dw,
                            input bit z, input bit n);
        bit mem, br, legal, taken, wr;
        int lat, dec_c, exe_c, m_lo, m_hi;
        mem   = (op == 0) || (op == 2);
        br    = (op == 3) || (op == 4);
        wr    = (op == 0) || (op == 1);
        legal = (op <= 4);
        taken = (op == 3) ? z : n;
        lat   = base_lat(op) + iw + (mem ? dw : 0);
        dec_c = iw + 2;
        exe_c = iw + 3;
        m_lo  = iw + 4;
        m_hi  = iw + 4 + dw;
        for (int c = 1; c <= lat; c++) begin
            chk("imem_req", IMEM_REQ, c <= iw + 1);
            chk("dmem_req", DMEM_REQ, mem && c >= m_lo && c <= m_hi);
            chk("ir_write", IR_WRITE, c == dec_c);
            if (c >= 2) chk("pc_write_fetch", PC_WRITE, c == dec_c);
            chk("branch", BRANCH, br && c == exe_c);
            chk("reg_write", REG_WRITE, wr && c == lat);
            chk("mem_read", MEM_READ, op == 0 && c >= m_lo && c <= m_hi);
            chk("mem_write", MEM_WRITE, op == 2 && c >= m_lo && c <= m_hi);
            if (legal && (c == exe_c || c == lat)) begin
                chk("alu_op", ALU_OP, exp_alu(op));
                chk("alu_src_b", ALU_SRC_B, (op == 1) ? 1 : 2);
                if (wr) begin
                    chk("reg_dst", REG_DST, op == 0);
                    chk("mem_to_reg", MEM_TO_REG, op == 1);
                end
            end
            OPCODE   = (c <= iw + 1) ? OP_W'(op) : OP_W'($urandom);
            IMEM_ACK = (c <= iw + 1) ? (c == iw + 1) : 1'($urandom);
            DMEM_ACK = (mem && c >= m_lo && c <= m_hi) ? (c == m_hi)
                                                       : 1'($urandom);
            ZERO  = (c == exe_c) ? z : 1'($urandom);
            NEG   = (c == exe_c) ? n : 1'($urandom);
            START = 1'($urandom);
            tick();
        end
        START    = 1'b0;
        IMEM_ACK = 1'b0;
        DMEM_ACK = 1'b0;
        if (legal || op == 15) model_cnt = sat_inc(model_cnt);
        if (legal) begin
            chk("next_fetch", IMEM_REQ, 1);
            chk("pc_write_br", PC_WRITE, br && taken);
            chk("pc_src", PC_SRC, br && taken);
            chk("halt_busy", HALT, 0);
        end else begin
            chk("halt", HALT, 1);
            chk("err", ERR, (op == 15) ? 0 : 1);
            chk("imem_req_halted", IMEM_REQ, 0);
        end
        chk("insn_count", INSN_COUNT, model_cnt);
    endtask

    task automatic restart();
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("restart_err", ERR, 0);
        chk("restart_halt", HALT, 0);
        chk("restart_req", IMEM_REQ, 1);
    endtask

    task automatic fetch_timeout();
        for (int c = 1; c <= TMO; c++) begin
            chk("to_imem_req", IMEM_REQ, 1);
            IMEM_ACK = 1'b0;
            tick();
        end
        chk("to_halt", HALT, 1);
        chk("to_err", ERR, 2);
        chk("to_req_drop", IMEM_REQ, 0);
        chk("to_count", INSN_COUNT, model_cnt);
    endtask

    task automatic load_dmem_timeout();
        OPCODE   = OP_W'(0);
        IMEM_ACK = 1'b1;
        tick();
        IMEM_ACK = 1'b0;
        tick();
        tick();
        for (int c = 1; c <= TMO; c++) begin
            chk("dto_dmem_req", DMEM_REQ, 1);
            chk("dto_mem_read", MEM_READ, 1);
            tick();
        end
        chk("dto_halt", HALT, 1);
        chk("dto_err", ERR, 2);
        chk("dto_req_drop", DMEM_REQ, 0);
        chk("dto_read_drop", MEM_READ, 0);
        chk("dto_no_wb", REG_WRITE, 0);
        chk("dto_count", INSN_COUNT, model_cnt);
    endtask

    task automatic reset_mid_store();
        OPCODE   = OP_W'(2);
        IMEM_ACK = 1'b1;
        tick();
        IMEM_ACK = 1'b0;
        tick();
        tick();
        chk("mid_mem_write", MEM_WRITE, 1);
        chk("mid_dmem_req", DMEM_REQ, 1);
        #2 RST_N = 1'b0;
        #1;
        model_cnt = 0;
        chk("ar_mem_write", MEM_WRITE, 0);
        chk("ar_dmem_req", DMEM_REQ, 0);
        chk("ar_imem_req", IMEM_REQ, 0);
        chk("ar_reg_write", REG_WRITE, 0);
        chk("ar_alu_op", ALU_OP, ADD);
        chk("ar_alu_src", ALU_SRC_B, 0);
        chk("ar_halt", HALT, 0);
        chk("ar_err", ERR, 0);
        chk("ar_count", INSN_COUNT, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        chk("ar_idle", IMEM_REQ, 0);
    endtask

    initial begin
        int op, ill;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_imem_req", IMEM_REQ, 0);
        chk("rst_dmem_req", DMEM_REQ, 0);
        chk("rst_reg_write", REG_WRITE, 0);
        chk("rst_ir_write", IR_WRITE, 0);
        chk("rst_pc_write", PC_WRITE, 0);
        chk("rst_alu_op", ALU_OP, ADD);
        chk("rst_halt", HALT, 0);
        chk("rst_err", ERR, 0);
        chk("rst_count", INSN_COUNT, 0);
        RST_N = 1'b1;
        IMEM_ACK = 1'b1;
        tick();
        IMEM_ACK = 1'b0;
        chk("idle_no_start", IMEM_REQ, 0);
        restart();

        run_insn(1, 0, 0, 0, 0);
        run_insn(0, 0, 3, 0, 0);
        run_insn(3, 0, 0, 1, 0);
        run_insn(3, 0, 0, 0, 0);
        run_insn(2, 1, 2, 0, 0);
        run_insn(4, 2, 0, 0, 1);
        run_insn(1, TMO - 1, 0, 0, 0);
        run_insn(0, 0, TMO - 1, 0, 0);
        run_insn(7, 0, 0, 0, 0);
        restart();
        fetch_timeout();
        restart();
        run_insn(15, 1, 0, 0, 0);
        restart();
        load_dmem_timeout();
        restart();

        reset_mid_store();
        restart();
        for (int i = 0; i < 5; i++) run_insn(1, 0, 0, 0, 0);
        chk("saturated", INSN_COUNT, CMAX);

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 19);
            if (op == 17) begin
                op = 15;
            end else if (op > 17) begin
                do ill = $urandom_range(5, 31); while (ill == 15);
                op = ill;
            end else begin
                op = op % 5;
            end
            run_insn(op, $urandom_range(0, TMO - 1),
                     $urandom_range(0, TMO - 1),
                     1'($urandom), 1'($urandom));
            if (op > 4) restart();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
